// File: rtl/ram_arb_pkg.sv
// Purpose: shared types for the instruction/data RAM port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ram_arb_pkg;

   // Which requester owns an outstanding response.
   typedef enum logic {
      OWNER_INSTR = 1'b0,
      OWNER_DATA  = 1'b1
   } owner_e;

   // One outstanding response: issued the cycle after its grant.
   typedef struct packed {
      logic   valid;
      owner_e owner;
      logic   err;
   } resp_t;

   // Bit positions in the two-bit request/grant vectors.
   localparam int unsigned PORT_INSTR = 0;
   localparam int unsigned PORT_DATA  = 1;

endpackage

// File: rtl/rr_arb2.sv
// Purpose: two-requester round-robin arbiter; on a tie the port not granted last wins.
// Latency: grant is combinational from req; the pointer updates on the clock edge.
// Backpressure: a losing requester is expected to hold req until granted.
// Ports: clk_i, rst_ni; req[1:0] (bit0 instr, bit1 data) -> gnt[1:0] one-hot or zero.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // Owner of the most recent grant; reset to instr so data wins the first tie.
   owner_e last_q;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_q == OWNER_INSTR) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= OWNER_INSTR;
      end else if (|gnt) begin
         last_q <= gnt[PORT_DATA] ? OWNER_DATA : OWNER_INSTR;
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Purpose: shares one single-port RAM between an instruction-fetch port and a load/store port.
// Latency: grant same cycle as req; rvalid/rdata/err exactly one cycle after the grant.
// Backpressure: at most one grant per cycle; the losing port holds req/addr until granted.
// Ports: clk_i, rst_ni; instr_* fetch handshake; data_* load/store handshake;
//        ram_* request to the RAM and its one-cycle-later response (ram_rvalid_i, ram_rdata_i).
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned Depth = 16384
) (
   input  logic        clk_i,
   input  logic        rst_ni,

   input  logic        instr_req_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic        instr_err_o,
   input  logic [31:0] instr_addr_i,
   output logic [31:0] instr_rdata_o,

   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic        data_err_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,

   output logic        ram_req_o,
   output logic        ram_we_o,
   output logic [3:0]  ram_be_o,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_wdata_o,
   input  logic        ram_rvalid_i,
   input  logic [31:0] ram_rdata_i
);

   // 33 bits so Depth*4 == 4 GiB still compares correctly.
   localparam logic [32:0] AddrLimit = 33'(Depth) * 33'd4;

   logic [1:0]  req;
   logic [1:0]  gnt;
   logic        gnt_any;
   logic        gnt_data;
   logic [31:0] win_addr;
   logic        in_range;
   resp_t       resp_d;
   resp_t       resp_q;
   logic        resp_err;
   logic [31:0] resp_rdata;

   assign req = {data_req_i, instr_req_i};

   rr_arb2 u_rr_arb2 (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req    (req),
      .gnt    (gnt)
   );

   assign gnt_any     = |gnt;
   assign gnt_data    = gnt[PORT_DATA];
   assign instr_gnt_o = gnt[PORT_INSTR];
   assign data_gnt_o  = gnt[PORT_DATA];

   assign win_addr = gnt_data ? data_addr_i : instr_addr_i;
   assign in_range = {1'b0, win_addr} < AddrLimit;

   // Out-of-range grants never touch the RAM; ram_req_o is also held off in reset.
   assign ram_req_o   = gnt_any & in_range & rst_ni;
   assign ram_addr_o  = win_addr;
   // Fetches are always full-word reads.
   assign ram_we_o    = gnt_data & data_we_i;
   assign ram_be_o    = gnt_data ? data_be_i : 4'hF;
   assign ram_wdata_o = gnt_data ? data_wdata_i : 32'h0;

   always_comb begin
      resp_d       = '0;
      resp_d.valid = gnt_any;
      resp_d.owner = gnt_data ? OWNER_DATA : OWNER_INSTR;
      resp_d.err   = ~in_range;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         resp_q <= '0;
      end else begin
         resp_q <= resp_d;
      end
   end

   // A missing RAM response for an in-range grant is reported as an error
   // rather than silently dropped. Stray ram_rvalid_i with nothing pending
   // is ignored because resp_q.valid gates everything below.
   assign resp_err   = resp_q.err | ~ram_rvalid_i;
   assign resp_rdata = resp_err ? 32'h0 : ram_rdata_i;

   assign instr_rvalid_o = resp_q.valid & (resp_q.owner == OWNER_INSTR);
   assign data_rvalid_o  = resp_q.valid & (resp_q.owner == OWNER_DATA);
   assign instr_err_o    = instr_rvalid_o & resp_err;
   assign data_err_o     = data_rvalid_o & resp_err;
   assign instr_rdata_o  = instr_rvalid_o ? resp_rdata : 32'h0;
   assign data_rdata_o   = data_rvalid_o ? resp_rdata : 32'h0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Purpose: directed self-checking bench for ram_port_arbiter with a one-cycle RAM model.
// Latency: inputs driven at negedge, grants checked mid-low phase, responses 1 ns after posedge.
// Backpressure: losing port holds req/addr stable until granted.
module tb_ram_port_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        instr_req_i;
   logic        instr_gnt_o;
   logic        instr_rvalid_o;
   logic        instr_err_o;
   logic [31:0] instr_addr_i;
   logic [31:0] instr_rdata_o;
   logic        data_req_i;
   logic        data_gnt_o;
   logic        data_rvalid_o;
   logic        data_err_o;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic [31:0] data_rdata_o;
   logic        ram_req_o;
   logic        ram_we_o;
   logic [3:0]  ram_be_o;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_wdata_o;
   logic        ram_rvalid_i;
   logic [31:0] ram_rdata_i;

   // RAM model controls: drop suppresses the response, spur injects a stray one.
   logic        drop = 1'b0;
   logic        spur = 1'b0;
   logic        mdl_vld = 1'b0;
   logic [31:0] mdl_dat = 32'h0;

   int total = 0;
   int bad   = 0;

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] ram_fn(input logic [31:0] a);
      return (a == 32'h0) ? 32'h3FC00093 : (a ^ 32'hC0DE0000);
   endfunction

   always @(posedge clk_i) begin
      mdl_vld <= ram_req_o & ~drop;
      mdl_dat <= ram_fn(ram_addr_o);
   end

   assign ram_rvalid_i = mdl_vld | spur;
   assign ram_rdata_i  = mdl_dat;

   ram_port_arbiter #(.Depth(16384)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .instr_req_i    (instr_req_i),
      .instr_gnt_o    (instr_gnt_o),
      .instr_rvalid_o (instr_rvalid_o),
      .instr_err_o    (instr_err_o),
      .instr_addr_i   (instr_addr_i),
      .instr_rdata_o  (instr_rdata_o),
      .data_req_i     (data_req_i),
      .data_gnt_o     (data_gnt_o),
      .data_rvalid_o  (data_rvalid_o),
      .data_err_o     (data_err_o),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_rdata_o   (data_rdata_o),
      .ram_req_o      (ram_req_o),
      .ram_we_o       (ram_we_o),
      .ram_be_o       (ram_be_o),
      .ram_addr_o     (ram_addr_o),
      .ram_wdata_o    (ram_wdata_o),
      .ram_rvalid_i   (ram_rvalid_i),
      .ram_rdata_i    (ram_rdata_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dwe, input logic [3:0] dbe,
                        input logic [31:0] da, input logic [31:0] dwd);
      @(negedge clk_i);
      instr_req_i  = ir;
      instr_addr_i = ia;
      data_req_i   = dr;
      data_we_i    = dwe;
      data_be_i    = dbe;
      data_addr_i  = da;
      data_wdata_i = dwd;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic edge_sample();
      @(posedge clk_i);
      #1;
   endtask

   task automatic no_resp(input string tag);
      chk({tag, "_irv"}, 32'(instr_rvalid_o), 32'h0);
      chk({tag, "_drv"}, 32'(data_rvalid_o), 32'h0);
      chk({tag, "_ierr"}, 32'(instr_err_o), 32'h0);
      chk({tag, "_derr"}, 32'(data_err_o), 32'h0);
      chk({tag, "_irdata"}, instr_rdata_o, 32'h0);
      chk({tag, "_drdata"}, data_rdata_o, 32'h0);
   endtask

   initial begin
      rst_ni = 1'b0;
      instr_req_i = 1'b0; instr_addr_i = 32'h0;
      data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0;
      data_addr_i = 32'h0; data_wdata_i = 32'h0;

      // Reset state, and grant visible in reset while ram_req_o stays low.
      drive(1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      no_resp("rst");
      chk("rst_ignt", 32'(instr_gnt_o), 32'h1);
      chk("rst_ramreq", 32'(ram_req_o), 32'h0);
      edge_sample();
      no_resp("rst2");

      // Instruction fetch from 0x0.
      @(negedge clk_i);
      rst_ni = 1'b1;
      drive(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      chk("if_ignt", 32'(instr_gnt_o), 32'h1);
      chk("if_dgnt", 32'(data_gnt_o), 32'h0);
      chk("if_ramreq", 32'(ram_req_o), 32'h1);
      chk("if_ramwe", 32'(ram_we_o), 32'h0);
      chk("if_rambe", 32'(ram_be_o), 32'hF);
      chk("if_ramaddr", ram_addr_o, 32'h0);
      edge_sample();
      chk("if_irv", 32'(instr_rvalid_o), 32'h1);
      chk("if_irdata", instr_rdata_o, 32'h3FC00093);
      chk("if_ierr", 32'(instr_err_o), 32'h0);
      chk("if_drv", 32'(data_rvalid_o), 32'h0);

      // Byte-enabled store.
      drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h3FC, 32'h12345678);
      chk("st_dgnt", 32'(data_gnt_o), 32'h1);
      chk("st_ramreq", 32'(ram_req_o), 32'h1);
      chk("st_ramwe", 32'(ram_we_o), 32'h1);
      chk("st_rambe", 32'(ram_be_o), 32'h3);
      chk("st_ramaddr", ram_addr_o, 32'h3FC);
      chk("st_ramwdata", ram_wdata_o, 32'h12345678);
      edge_sample();
      chk("st_drv", 32'(data_rvalid_o), 32'h1);
      chk("st_derr", 32'(data_err_o), 32'h0);
      chk("st_irv", 32'(instr_rvalid_o), 32'h0);

      // rvalid is a single pulse.
      idle();
      edge_sample();
      no_resp("pulse");

      // Out-of-range load: granted, no RAM access, error response.
      drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10000, 32'h0);
      chk("oor_dgnt", 32'(data_gnt_o), 32'h1);
      chk("oor_ramreq", 32'(ram_req_o), 32'h0);
      edge_sample();
      chk("oor_drv", 32'(data_rvalid_o), 32'h1);
      chk("oor_derr", 32'(data_err_o), 32'h1);
      chk("oor_drdata", data_rdata_o, 32'h0);

      // Last in-range word is still in range.
      drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'hFFFC, 32'h0);
      chk("edge_ramreq", 32'(ram_req_o), 32'h1);
      edge_sample();
      chk("edge_derr", 32'(data_err_o), 32'h0);
      chk("edge_drdata", data_rdata_o, 32'hFFFC ^ 32'hC0DE0000);

      // RAM fails to respond: error reported, never dropped.
      drop = 1'b1;
      drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
      edge_sample();
      drop = 1'b0;
      chk("miss_drv", 32'(data_rvalid_o), 32'h1);
      chk("miss_derr", 32'(data_err_o), 32'h1);
      chk("miss_drdata", data_rdata_o, 32'h0);

      // Stray RAM response with nothing pending is ignored.
      idle();
      edge_sample();
      spur = 1'b1;
      #1;
      no_resp("spur");
      spur = 1'b0;

      // Fresh reset, then both ports contend for six cycles.
      @(negedge clk_i);
      rst_ni = 1'b0;
      edge_sample();
      edge_sample();
      @(negedge clk_i);
      rst_ni = 1'b1;
      for (int i = 0; i < 6; i++) begin
         logic exp_d;
         exp_d = (i % 2 == 0);
         drive(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
         chk($sformatf("rr%0d_dgnt", i), 32'(data_gnt_o), 32'(exp_d));
         chk($sformatf("rr%0d_ignt", i), 32'(instr_gnt_o), 32'(!exp_d));
         chk($sformatf("rr%0d_addr", i), ram_addr_o, exp_d ? 32'h200 : 32'h100);
         edge_sample();
         chk($sformatf("rr%0d_drv", i), 32'(data_rvalid_o), 32'(exp_d));
         chk($sformatf("rr%0d_irv", i), 32'(instr_rvalid_o), 32'(!exp_d));
         chk($sformatf("rr%0d_drdata", i), data_rdata_o,
             exp_d ? ram_fn(32'h200) : 32'h0);
         chk($sformatf("rr%0d_irdata", i), instr_rdata_o,
             exp_d ? 32'h0 : ram_fn(32'h100));
      end

      // Data grant in cycle N, reset half a cycle later: response discarded,
      // pointer returns to data-first.
      drive(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
      @(posedge clk_i);
      #5;
      rst_ni = 1'b0;
      #1;
      no_resp("mrst");
      idle();
      edge_sample();
      edge_sample();
      @(negedge clk_i);
      rst_ni = 1'b1;
      edge_sample();
      no_resp("mrst_rel");
      drive(1'b1, 32'h100, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
      chk("mrst_dgnt", 32'(data_gnt_o), 32'h1);
      chk("mrst_ignt", 32'(instr_gnt_o), 32'h0);
      edge_sample();
      chk("mrst_drv", 32'(data_rvalid_o), 32'h1);
      chk("mrst_drdata", data_rdata_o, ram_fn(32'h200));
      idle();
      edge_sample();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter Depth, default 16384, RAM size in 32-bit words; addressable window is bytes [0, Depth*4).
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  asynchronous, active-low reset.
REQ-004 instr_req_i / instr_gnt_o / instr_rvalid_o / instr_err_o  in/out/out/out  1 each  instruction-fetch handshake.
REQ-005 instr_addr_i  input  32  fetch byte address; instr_rdata_o  output  32  fetch data.
REQ-006 data_req_i / data_gnt_o / data_rvalid_o / data_err_o  in/out/out/out  1 each  load/store handshake.
REQ-007 data_we_i  input  1; data_be_i  input  4; data_addr_i  input  32; data_wdata_i  input  32; data_rdata_o  output  32.
REQ-008 ram_req_o  output  1; ram_we_o  output  1; ram_be_o  output  4; ram_addr_o  output  32; ram_wdata_o  output  32  single-port RAM request.
REQ-009 ram_rvalid_i  input  1; ram_rdata_i  input  32  RAM response, exactly one cycle after ram_req_o.

Function
REQ-010 Grant is combinational: a port's gnt is high in the same cycle as its req when that port wins arbitration.
REQ-011 At most one grant per cycle; a port whose req is not granted holds req and address stable until granted.
REQ-012 Only one requester -> that requester wins.
REQ-013 Both requesting -> round-robin: winner is the port not granted in the most recent cycle with a grant; after reset data has priority.
REQ-014 Granted in-range request -> ram_req_o=1, ram_addr_o=winner address, ram_we_o/ram_be_o/ram_wdata_o from data port, or 0/4'hF/0 for instruction port.
REQ-015 Instruction port is read-only; no instruction request ever drives ram_we_o=1.
REQ-016 Out-of-range request (addr >= Depth*4) is granted but SHALL NOT assert ram_req_o.
REQ-017 Every grant registers a pending response: owner (instr/data) and error flag.
REQ-018 Cycle after a grant: owner's rvalid=1; in-range -> rdata=ram_rdata_i, err=0; out-of-range -> rdata=0, err=1.
REQ-019 Non-owner rvalid=0 and rdata=0 in every cycle; rvalid is a single-cycle pulse per grant.
REQ-020 Back-to-back grants on consecutive cycles sustained (one grant and one response per cycle, throughput 1).
REQ-021 Store responses also return rvalid (rdata = RAM read-before-write value, don't-care for checking).
REQ-022 In-range pending response with ram_rvalid_i=0 -> still assert rvalid with err=1 (protocol violation reported, never dropped).
REQ-023 ram_rvalid_i=1 with no pending in-range request -> ignored.

Reset
REQ-024 Reset asserted: pending flag cleared, last-granted pointer = instr (so data wins first tie), all rvalid/err outputs 0, rdata outputs 0.
REQ-025 Reset mid-transaction discards the pending response; no rvalid is emitted after reset release for pre-reset grants.
REQ-026 Combinational grant/RAM outputs follow inputs during reset but ram_req_o SHALL be forced 0 while rst_ni=0.

Structure
REQ-027 Package ram_arb_pkg holds owner enum (OWNER_INSTR, OWNER_DATA) and the response-record struct (valid, owner, err).
REQ-028 Sub-module rr_arb2 (two-requester round-robin arbiter, req[1:0] -> gnt[1:0], pointer register) is instantiated once.
REQ-029 No memory inside this block; it connects directly to the project single-port RAM.

Verification
REQ-030 Instr-only read addr 0x0, RAM returns 0x3FC00093 -> instr_gnt same cycle, instr_rvalid next cycle with rdata 0x3FC00093, err 0.
REQ-031 Data store addr 0x3FC, be 4'b0011, wdata 0x12345678 -> ram_we_o=1, ram_be_o=4'b0011, ram_addr_o=0x3FC; data_rvalid next cycle.
REQ-032 Both ports request continuously for 6 cycles after reset -> grants data,instr,data,instr,data,instr; responses routed to matching port.
REQ-033 Data load addr 0x10000 (Depth=16384) -> data_gnt=1, ram_req_o=0, next cycle data_rvalid=1, err=1, rdata=0.
REQ-034 Grant in cycle N, rst_ni low at N+0.5 for 2 cycles -> no rvalid on either port after release; first tie after reset goes to data.
